// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the requester handshakes (fetch port F, data port D) and the
// single-port memory bus that mem_port_arbiter sequences.
//   slave  : arbiter view (takes requests and read data, drives done/rdata/mem_*)
//   master : environment view (control unit requesters plus the memory)
// Signals:
//   f_req/f_addr -> f_done/f_rdata                     fetch handshake (read-only)
//   d_req/d_we/d_addr/d_wdata -> d_done/d_rdata        data/stack handshake
//   mem_addr/mem_wdata/mem_we -> mem_rdata             memory bus (1-cycle read latency)
//   busy, owner                                        arbiter status
interface mem_port_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             f_req;
    logic [WIDTH-1:0] f_addr;
    logic             f_done;
    logic [WIDTH-1:0] f_rdata;

    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_done;
    logic [WIDTH-1:0] d_rdata;

    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    logic             busy;
    logic             owner;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_done, f_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_we, busy, owner
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_done, f_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_we, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port data memory between instruction fetch (F, read-only)
// and data/stack access (D, read or write). D has fixed priority, but after
// STARVE_LIMIT consecutive D grants with F pending, F is forced through.
// Each access is IDLE -> ACCESS -> RESP: grant edge to done pulse is 2 cycles,
// back-to-back issue interval is 3 cycles. All outputs are registered.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high; drops any access in flight
//   bus   : mem_port_arbiter_if.slave (requester handshakes, memory bus, busy/owner)
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 2,
    parameter int WIDTH        = 16
) (
    input logic               clock,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);

    state_t           state;
    logic [1:0]       starve_cnt;
    logic             acc_we;      // write flag of the access in flight; mem_we drops after ACCESS
    logic             d_wins;

    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic [WIDTH-1:0] f_rdata_q;
    logic [WIDTH-1:0] d_rdata_q;
    logic             mem_we_q;
    logic             f_done_q;
    logic             d_done_q;
    logic             busy_q;
    logic             owner_q;

    // D wins unless F has waited through STARVE_LIMIT D grants in a row.
    always_comb begin
        d_wins = bus.d_req && !(bus.f_req && (starve_cnt == STARVE_MAX));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            acc_we      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_we_q    <= 1'b0;
            f_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            f_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.f_req || bus.d_req) begin
                        state  <= ACCESS;
                        busy_q <= 1'b1;
                        if (d_wins) begin
                            owner_q     <= 1'b1;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                            mem_we_q    <= bus.d_we;
                            acc_we      <= bus.d_we;
                            if (!bus.f_req) begin
                                starve_cnt <= '0;
                            end else if (starve_cnt != STARVE_MAX) begin
                                starve_cnt <= starve_cnt + 2'd1;
                            end
                        end else begin
                            owner_q    <= 1'b0;
                            mem_addr_q <= bus.f_addr;
                            mem_we_q   <= 1'b0;
                            acc_we     <= 1'b0;
                            starve_cnt <= '0;
                        end
                    end else begin
                        // f_req is low here, so F is not being starved
                        starve_cnt <= '0;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                    if (owner_q) begin
                        d_done_q <= 1'b1;
                        if (!acc_we) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        f_done_q  <= 1'b1;
                        f_rdata_q <= bus.mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.f_done    = f_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a 64K-word memory whose write strobe
// is qualified by system reset, a cycle-age reference model, a per-cycle
// compare process and literal checks for each scenario.
module tb_mem_port_arbiter;
    localparam int W  = 16;
    localparam int SL = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.WIDTH(W)) bus();

    mem_port_arbiter #(.STARVE_LIMIT(SL), .WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory (1-cycle read latency) ----------------
    logic         pl_en;
    logic [W-1:0] pl_addr;
    logic [W-1:0] pl_data;
    logic [W-1:0] mem [0:65535];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clock);
            if (pl_en) mem[pl_addr] <= pl_data;
            else if (bus.mem_we && !reset) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // ---------------- reference model ----------------
    logic [W-1:0] ref_mem [0:65535];
    logic         e_f_done, e_d_done, e_mem_we, e_busy, e_owner;
    logic [W-1:0] e_f_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;

    initial begin
        int           edge_n;
        int           g_edge;
        bit           active;
        int           d_run;
        bit           g_owner, g_we;
        logic [W-1:0] g_addr, g_wdata, g_rd;
        for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
        edge_n = 0; g_edge = 0; active = 0; d_run = 0;
        g_owner = 0; g_we = 0; g_addr = '0; g_wdata = '0; g_rd = '0;
        {e_f_done, e_d_done, e_mem_we, e_busy, e_owner} = '0;
        {e_f_rdata, e_d_rdata, e_mem_addr, e_mem_wdata} = '0;
        forever begin
            @(posedge clock);
            edge_n++;
            if (pl_en) ref_mem[pl_addr] = pl_data;
            if (reset) begin
                active = 0;
                d_run  = 0;
                {e_f_done, e_d_done, e_mem_we, e_busy, e_owner} = '0;
                {e_f_rdata, e_d_rdata, e_mem_addr, e_mem_wdata} = '0;
            end else begin
                e_f_done = 0;
                e_d_done = 0;
                if (active) begin
                    if (edge_n - g_edge == 1) begin
                        e_mem_we = 0;
                        if (g_we) ref_mem[g_addr] = g_wdata;
                    end else begin
                        e_busy = 0;
                        active = 0;
                        if (g_owner) begin
                            e_d_done = 1;
                            if (!g_we) e_d_rdata = g_rd;
                        end else begin
                            e_f_done  = 1;
                            e_f_rdata = g_rd;
                        end
                    end
                end else if (bus.f_req || bus.d_req) begin
                    if (bus.d_req && !(bus.f_req && d_run >= SL)) begin
                        g_owner     = 1;
                        g_addr      = bus.d_addr;
                        g_we        = bus.d_we;
                        g_wdata     = bus.d_wdata;
                        e_mem_wdata = bus.d_wdata;
                        if (bus.f_req) begin
                            if (d_run < SL) d_run++;
                        end else begin
                            d_run = 0;
                        end
                    end else begin
                        g_owner = 0;
                        g_addr  = bus.f_addr;
                        g_we    = 0;
                        d_run   = 0;
                    end
                    g_rd       = ref_mem[g_addr];
                    g_edge     = edge_n;
                    active     = 1;
                    e_busy     = 1;
                    e_owner    = g_owner;
                    e_mem_addr = g_addr;
                    e_mem_we   = g_we;
                end else begin
                    d_run = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (chk_on) begin
                check1("f_done", bus.f_done, e_f_done);
                check1("d_done", bus.d_done, e_d_done);
                check1("mem_we", bus.mem_we, e_mem_we);
                check1("busy", bus.busy, e_busy);
                check1("owner", bus.owner, e_owner);
                check("f_rdata", bus.f_rdata, e_f_rdata);
                check("d_rdata", bus.d_rdata, e_d_rdata);
                check("mem_addr", bus.mem_addr, e_mem_addr);
                check("mem_wdata", bus.mem_wdata, e_mem_wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for the selected done pulse; reports ticks taken and ticks with mem_we high.
    task automatic wait_done(input bit want_d, input string name, output int cycles, output int we_cycles);
        cycles = 0;
        we_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cycles++;
            if (bus.mem_we) we_cycles++;
            if (want_d ? bus.d_done : bus.f_done) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    endtask

    task automatic wait_busy(input string name);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.busy) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_busy_timeout: got busy 0 expected 1 within 10 cycles", name);
    endtask

    initial begin
        int lat, wec, cnt, bcnt, n_done;
        bit got_ord [6];
        int stamp [6];
        bit exp_ord [6];
        exp_ord = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bus.f_req = 0; bus.f_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        pl_en = 0; pl_addr = '0; pl_data = '0;
        reset = 1;
        tick();
        chk_on = 1;
        pl_en = 1; pl_addr = 16'h0010; pl_data = 16'hBEEF;
        tick();
        pl_addr = 16'h0020; pl_data = 16'h5555;
        tick();
        pl_en = 0;
        tick();
        check("reset_f_rdata", bus.f_rdata, 16'h0000);
        check("reset_mem_addr", bus.mem_addr, 16'h0000);
        check1("reset_busy", bus.busy, 1'b0);
        reset = 0;
        tick();

        // 1: single fetch
        bus.f_addr = 16'h0010; bus.f_req = 1;
        wait_done(0, "t1", lat, wec);
        bus.f_req = 0;
        check_int("t1_latency", lat, 3);
        check("t1_f_rdata", bus.f_rdata, 16'hBEEF);
        check("t1_d_rdata", bus.d_rdata, 16'h0000);
        tick();

        // 2: D write then D read back
        bus.d_we = 1; bus.d_addr = 16'h7FFE; bus.d_wdata = 16'h1234; bus.d_req = 1;
        wait_done(1, "t2w", lat, wec);
        bus.d_req = 0;
        check_int("t2_we_cycles", wec, 1);
        check("t2_mem_word", mem[16'h7FFE], 16'h1234);
        tick();
        bus.d_we = 0; bus.d_req = 1;
        wait_done(1, "t2r", lat, wec);
        bus.d_req = 0;
        check_int("t2_read_we_cycles", wec, 0);
        check("t2_d_rdata", bus.d_rdata, 16'h1234);
        check("t2_f_rdata", bus.f_rdata, 16'hBEEF);
        tick();

        // 3: both held continuously -> D,D,F,D,D,F every 3 cycles
        bus.f_addr = 16'h0010; bus.f_req = 1;
        bus.d_we = 0; bus.d_addr = 16'h7FFE; bus.d_req = 1;
        n_done = 0;
        for (int c = 0; c < 40 && n_done < 6; c++) begin
            tick();
            if (bus.f_done || bus.d_done) begin
                got_ord[n_done] = bus.d_done;
                stamp[n_done] = c;
                n_done++;
            end
        end
        bus.f_req = 0; bus.d_req = 0;
        check_int("t3_done_count", n_done, 6);
        for (int i = 0; i < 6; i++) check1($sformatf("t3_owner_%0d", i), got_ord[i], exp_ord[i]);
        for (int i = 1; i < 6; i++) check_int($sformatf("t3_gap_%0d", i), stamp[i] - stamp[i-1], 3);
        tick();

        // 4: simultaneous first request, D wins, F follows on next slot
        bus.f_req = 1; bus.d_req = 1;
        wait_done(1, "t4d", lat, wec);
        bus.d_req = 0;
        check_int("t4_d_latency", lat, 3);
        check1("t4_no_f_yet", bus.f_done, 1'b0);
        wait_done(0, "t4f", lat, wec);
        bus.f_req = 0;
        check_int("t4_f_gap", lat, 3);
        tick();

        // 5: reset during ACCESS of a D write
        bus.d_we = 1; bus.d_addr = 16'h0020; bus.d_wdata = 16'hAAAA; bus.d_req = 1;
        wait_busy("t5");
        check1("t5_we_in_access", bus.mem_we, 1'b1);
        reset = 1;
        tick();
        check1("t5_we_after_reset", bus.mem_we, 1'b0);
        check("t5_mem_addr", bus.mem_addr, 16'h0000);
        check("t5_f_rdata", bus.f_rdata, 16'h0000);
        reset = 0; bus.d_req = 0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.d_done) cnt++;
        end
        check_int("t5_no_done", cnt, 0);
        check("t5_mem_word", mem[16'h0020], 16'h5555);
        bus.d_we = 0; bus.d_req = 1;
        wait_done(1, "t5r", lat, wec);
        bus.d_req = 0;
        check("t5_readback", bus.d_rdata, 16'h5555);
        tick();

        // 6: d_req dropped during ACCESS
        bus.d_we = 0; bus.d_addr = 16'h0010; bus.d_req = 1;
        wait_busy("t6");
        bus.d_req = 0;
        cnt = 0; bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.d_done) cnt++;
            if (bus.busy) bcnt++;
        end
        check_int("t6_done_once", cnt, 1);
        check_int("t6_busy_cycles", bcnt, 1);
        check("t6_d_rdata", bus.d_rdata, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences the single-port 16-bit data memory and shares it between two requesters: instruction fetch (port F, read-only) and data/stack access (port D, read or write). It sits between the control unit and the memory datapath, driving the memory's address, write-data and write-enable. Arbitration is fixed priority to D, with a starvation guard that forces a fetch grant after a bounded run of D grants.

Parameters:
STARVE_LIMIT, 2, consecutive D grants allowed while F is pending before F is forced (range 1-3)
WIDTH, 16, address and data width

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
f_req  in  1  fetch request; held high until f_done
f_addr  in  WIDTH  fetch address (pc); stable while f_req high
f_done  out  1  one-cycle pulse, fetch complete, f_rdata valid
f_rdata  out  WIDTH  fetched word, held until next F completion
d_req  in  1  data request; held high until d_done
d_we  in  1  1 = write, 0 = read; stable while d_req high
d_addr  in  WIDTH  data address (imm, register, sp-derived)
d_wdata  in  WIDTH  store data
d_done  out  1  one-cycle pulse, data access complete
d_rdata  out  WIDTH  loaded word, held until next D read completion
mem_addr  out  WIDTH  memory address
mem_wdata  out  WIDTH  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  WIDTH  memory read data, valid one cycle after address presented
busy  out  1  high in ACCESS and RESP
owner  out  1  0 = F, 1 = D; owner of current or last access

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state IDLE; f_done, d_done, mem_we, busy, owner = 0; mem_addr, mem_wdata, f_rdata, d_rdata = 0; starve_cnt = 0.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: if any req is high, select a winner, latch its addr/wdata/we into the mem_* registers, set owner, and go to ACCESS. Otherwise stay.
- Selection: D wins if d_req is high, unless f_req is high and starve_cnt == STARVE_LIMIT, in which case F wins. If only one request is high, it wins.
- starve_cnt: incremented when D wins while f_req is high; cleared when F wins or when f_req is low. Saturates at STARVE_LIMIT.
- ACCESS (exactly 1 cycle): mem_addr/mem_wdata/mem_we are driven; memory writes on the closing edge when mem_we = 1. Go to RESP. mem_we is cleared on that edge.
- RESP (exactly 1 cycle):
  - Capture mem_rdata into f_rdata (owner 0) or d_rdata (owner 1, read only); writes leave d_rdata unchanged.
  - Pulse the owner's done.
  - Go to IDLE. The next grant is evaluated in IDLE the following cycle.
- Latency: grant edge to done = 2 cycles; back-to-back issue interval = 3 cycles.
- Requesters drop req in the cycle after done. A req still high in IDLE is treated as a new request.
- A req deasserted mid-access does not abort; the access completes and done still pulses.
- Requests and operands are sampled only in IDLE; changes during ACCESS/RESP are ignored.
- Reset during ACCESS: mem_we forced to 0 at that edge, access dropped, no done pulse.
- Widths: no arithmetic; all paths are WIDTH bits, no truncation.

Test Plan:
1. Reset, then f_req=1, f_addr=0x0010, memory[0x0010]=0xBEEF → mem_addr=0x0010 in ACCESS; f_done pulses 2 cycles after grant; f_rdata=0xBEEF; d_done stays 0.
2. d_req=1, d_we=1, d_addr=0x7FFE, d_wdata=0x1234 → mem_we=1 for exactly one cycle, d_done pulses; then a D read of 0x7FFE → d_rdata=0x1234, f_rdata unchanged.
3. f_req and d_req both held continuously, STARVE_LIMIT=2 → grant order D,D,F,D,D,F; done pulses every 3 cycles, alternating accordingly.
4. Simultaneous first request with starve_cnt=0 → D granted first; F completes on the next slot, 3 cycles later.
5. Reset asserted during ACCESS of a D write to 0x0020 (old value 0x5555) → mem_we=0 next cycle, no d_done, memory[0x0020] still 0x5555, all outputs 0.
6. d_req dropped during ACCESS → d_done still pulses once; no second access issued.
